// File: rtl/conv_loop_sequencer_if.sv
// Index/handshake bundle between the conv loop sequencer (master) and the
// conv address controller / accumulator framing logic (slave).
interface conv_loop_sequencer_if;
   logic        start;
   logic        stall;
   logic [7:0]  m;
   logic [7:0]  r;
   logic [7:0]  c;
   logic [7:0]  n;
   logic [3:0]  i;
   logic [3:0]  j;
   logic        idx_valid;
   logic        first_tap;
   logic        last_tap;
   logic        busy;
   logic        done;
   logic [31:0] stall_cycles;

   modport master (
      input  start, stall,
      output m, r, c, n, i, j, idx_valid, first_tap, last_tap, busy, done, stall_cycles
   );

   modport slave (
      output start, stall,
      input  m, r, c, n, i, j, idx_valid, first_tap, last_tap, busy, done, stall_cycles
   );
endinterface

// File: rtl/conv_loop_sequencer.sv
// Nested conv loop index generator (m, r, c, n, i, j; j innermost), one tuple per
// unstalled RUN cycle. Optional stall counter enabled by `define LOOP_STALL_CNT_EN.
module conv_loop_sequencer #(
   parameter int K           = 5,
   parameter int OUT_SIZE    = 28,
   parameter int OUT_CHANNEL = 6,
   parameter int IN_CHANNEL  = 1,
   parameter int N_STEP      = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   conv_loop_sequencer_if.master sif
);

   localparam logic [31:0] J_LIM = 32'(K - 1);
   localparam logic [31:0] I_LIM = 32'(K - 1);
   localparam logic [31:0] N_LIM = 32'((IN_CHANNEL - 1) * N_STEP);
   localparam logic [31:0] C_LIM = 32'(OUT_SIZE - 1);
   localparam logic [31:0] R_LIM = 32'(OUT_SIZE - 1);
   localparam logic [31:0] M_LIM = 32'(OUT_CHANNEL - 1);
   localparam logic [7:0]  N_INC = 8'(N_STEP);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e     state_q, state_d;
   logic [7:0] m_q, m_d, r_q, r_d, c_q, c_d, n_q, n_d;
   logic [3:0] i_q, i_d, j_q, j_d;

   logic advance;
   logic j_end, i_end, n_end, c_end, r_end, m_end;

   // Limit tests in 32-bit unsigned so no parameter set can alias a narrow index.
   always_comb begin
      j_end = (32'(j_q) == J_LIM);
      i_end = (32'(i_q) == I_LIM);
      n_end = (32'(n_q) == N_LIM);
      c_end = (32'(c_q) == C_LIM);
      r_end = (32'(r_q) == R_LIM);
      m_end = (32'(m_q) == M_LIM);
   end

   assign advance = (state_q == RUN) && !sif.stall;

   always_comb begin
      state_d = state_q;
      m_d = m_q;
      r_d = r_q;
      c_d = c_q;
      n_d = n_q;
      i_d = i_q;
      j_d = j_q;
      case (state_q)
         IDLE: if (sif.start) state_d = RUN;
         RUN: begin
            if (advance) begin
               if (m_end && r_end && c_end && n_end && i_end && j_end) begin
                  state_d = DONE;
                  m_d = '0;
                  r_d = '0;
                  c_d = '0;
                  n_d = '0;
                  i_d = '0;
                  j_d = '0;
               end else if (!j_end) begin
                  j_d = j_q + 4'd1;
               end else begin
                  j_d = '0;
                  if (!i_end) begin
                     i_d = i_q + 4'd1;
                  end else begin
                     i_d = '0;
                     if (!n_end) begin
                        n_d = n_q + N_INC;
                     end else begin
                        n_d = '0;
                        if (!c_end) begin
                           c_d = c_q + 8'd1;
                        end else begin
                           c_d = '0;
                           if (!r_end) begin
                              r_d = r_q + 8'd1;
                           end else begin
                              r_d = '0;
                              m_d = m_q + 8'd1;
                           end
                        end
                     end
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         m_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         n_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         r_q     <= r_d;
         c_q     <= c_d;
         n_q     <= n_d;
         i_q     <= i_d;
         j_q     <= j_d;
      end
   end

   assign sif.m         = m_q;
   assign sif.r         = r_q;
   assign sif.c         = c_q;
   assign sif.n         = n_q;
   assign sif.i         = i_q;
   assign sif.j         = j_q;
   assign sif.idx_valid = advance;
   assign sif.first_tap = advance && (n_q == 8'd0) && (i_q == 4'd0) && (j_q == 4'd0);
   assign sif.last_tap  = advance && n_end && i_end && j_end;
   assign sif.busy      = (state_q == RUN);
   assign sif.done      = (state_q == DONE);

`ifdef LOOP_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Cleared on sweep start so the value read after done covers exactly one sweep.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == IDLE && sif.start)
         stall_cnt_d = '0;
      else if (state_q == RUN && sif.stall && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign sif.stall_cycles = stall_cnt_q;
`else
   assign sif.stall_cycles = '0;
`endif

endmodule
